gvt_arbiter: RTL and testbench
==============================

GVT_ARBITER -- requirements
Module: gvt_arbiter

Interface
REQ-001 SHALL have parameter N_TILES, default 8, number of tiles polled per round.
REQ-002 SHALL have parameter TS_WIDTH, default 32, timestamp width.
REQ-003 SHALL have parameter TB_WIDTH, default 32, tiebreaker width; VW = TS_WIDTH+TB_WIDTH.
REQ-004 SHALL have parameter LOG_GVT_PERIOD, default 5, log2 of round period in cycles.
REQ-005 SHALL have ports: clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have ports: rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports: gvt_en  input  1  enables periodic rounds.
REQ-008 SHALL have ports: lvt_req  output  N_TILES  per-tile LVT request pulse.
REQ-009 SHALL have ports: lvt_valid  input  N_TILES  per-tile LVT response strobe.
REQ-010 SHALL have ports: lvt  input  N_TILES*VW  per-tile {ts,tb}, tile i at bits [i*VW +: VW].
REQ-011 SHALL have ports: gvt  output  VW  last published global virtual time {ts,tb}.
REQ-012 SHALL have ports: gvt_valid  output  1  one-cycle publish strobe.
REQ-013 SHALL have ports: done  output  1  sticky termination flag.

Function
REQ-014 SHALL implement FSM states IDLE, SAMPLE, COLLECT, REDUCE, PUBLISH.
REQ-015 SHALL run a LOG_GVT_PERIOD-bit period counter incrementing each cycle while gvt_en=1; held at 0 while gvt_en=0.
REQ-016 SHALL move IDLE->SAMPLE when the counter wraps to 0 and gvt_en=1; a wrap in any other state SHALL be dropped, not queued.
REQ-017 SHALL, in SAMPLE (one cycle), drive lvt_req all-ones, clear per-tile received flags, then enter COLLECT.
REQ-018 SHALL, in COLLECT, latch lvt[i] and set flag i on lvt_valid[i]=1; lvt_valid outside COLLECT is ignored; a repeat strobe overwrites the latched value.
REQ-019 SHALL leave COLLECT the cycle after all N_TILES flags are set (including flags set that cycle); no timeout.
REQ-020 SHALL, in REDUCE, compare one tile per cycle, index 0..N_TILES-1, keeping a running minimum seeded to all-ones; exactly N_TILES cycles.
REQ-021 SHALL compare {ts,tb} as a single VW-bit unsigned value; ties keep the current minimum.
REQ-022 SHALL, in PUBLISH (one cycle), load gvt with the minimum, assert gvt_valid, set done if the minimum is all-ones, return to IDLE.
REQ-023 SHALL complete a started round if gvt_en falls mid-round, then remain in IDLE.
REQ-024 SHALL assert gvt_valid exactly N_TILES+1 cycles after the cycle in which the last lvt_valid is sampled.
REQ-025 SHALL hold gvt between publishes; done SHALL remain set until reset.

Reset
REQ-026 SHALL on rstn=0, asynchronously: state IDLE, counter 0, flags 0, lvt_req 0, gvt 0, gvt_valid 0, done 0.
REQ-027 SHALL abandon any in-progress round on reset; no publish follows release.

Configuration
REQ-028 SHALL honour macro GVT_MONOTONIC_CHECK_EN: when defined, a computed minimum below the current gvt SHALL not update gvt, SHALL still pulse gvt_valid, and SHALL set a sticky output gvt_err (1 bit, reset 0).
REQ-029 SHALL, without GVT_MONOTONIC_CHECK_EN, omit gvt_err and publish every computed minimum unconditionally.

Verification
REQ-030 SHALL cover: N_TILES=8, gvt_en=1, all tiles respond 1 cycle after lvt_req with ts=10*i+5, tb=i -> gvt={5,0}, gvt_valid 9 cycles after responses.
REQ-031 SHALL cover: tiles 2 and 6 both report {7,3}, others {9,0} -> gvt={7,3}.
REQ-032 SHALL cover: tile 4 responds 100 cycles late -> no counter-wrap round starts meanwhile; single publish after tile 4.
REQ-033 SHALL cover: all tiles report all-ones -> gvt all-ones, done=1 and stays 1 over later rounds.
REQ-034 SHALL cover: rstn pulsed low during REDUCE -> outputs at reset values, no gvt_valid until next round completes.
REQ-035 SHALL cover (macro on): round 1 yields {20,0}, round 2 yields {15,0} -> gvt stays {20,0}, gvt_err=1.

Source files
------------

// File: rtl/gvt_arbiter.sv
// Purpose : periodic GVT round controller; polls N_TILES tiles for their local
//           virtual time {ts,tb}, reduces to the minimum and publishes it as GVT.
// Latency : gvt/gvt_valid appear N_TILES+1 cycles after the last lvt_valid is sampled.
// Backpressure: none; a round waits indefinitely in COLLECT for every tile to
//               answer, and period wraps that occur while a round is busy are dropped.
// Ports   : clk/rstn        clock, async active-low reset
//           gvt_en          enables the free-running round period counter
//           lvt_req         per-tile one-cycle request pulse (SAMPLE state)
//           lvt_valid/lvt   per-tile response strobe and {ts,tb}, tile i at [i*VW +: VW]
//           gvt/gvt_valid   last published minimum and its one-cycle strobe
//           done            sticky, set when a published minimum is all-ones
//           gvt_err         (GVT_MONOTONIC_CHECK_EN only) sticky, set when a minimum
//                           below the current gvt was computed and suppressed
// Build option: define GVT_MONOTONIC_CHECK_EN to enable the monotonicity guard.
module gvt_arbiter #(
  parameter int N_TILES        = 8,
  parameter int TS_WIDTH       = 32,
  parameter int TB_WIDTH       = 32,
  parameter int LOG_GVT_PERIOD = 5,
  localparam int VW            = TS_WIDTH + TB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  gvt_en,
  output logic [N_TILES-1:0]    lvt_req,
  input  logic [N_TILES-1:0]    lvt_valid,
  input  logic [N_TILES*VW-1:0] lvt,
  output logic [VW-1:0]         gvt,
  output logic                  gvt_valid,
  output logic                  done
`ifdef GVT_MONOTONIC_CHECK_EN
  ,
  output logic                  gvt_err
`endif
);

  localparam int IW = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SAMPLE  = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_REDUCE  = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [LOG_GVT_PERIOD-1:0] cnt_q;
  logic [N_TILES-1:0]        flags_q;
  logic [VW-1:0]             lat_q [N_TILES];
  logic [IW-1:0]             idx_q;
  logic [VW-1:0]             min_q;
  logic [VW-1:0]             gvt_q;
  logic                      gvt_valid_q;
  logic                      done_q;

  logic          wrap;
  logic          last_cmp;
  logic [VW-1:0] cand;
  logic [VW-1:0] min_next;

  // Wrap is the cycle in which the counter rolls over from all-ones to 0.
  assign wrap     = gvt_en && (cnt_q == '1);
  assign last_cmp = (idx_q == IW'(N_TILES - 1));
  assign cand     = lat_q[idx_q];
  // Strict less-than: on a tie the earlier (current) minimum is kept.
  assign min_next = (cand < min_q) ? cand : min_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (!gvt_en) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + LOG_GVT_PERIOD'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (wrap) state_d = S_SAMPLE;
      S_SAMPLE:  state_d = S_COLLECT;
      // Responses arriving this cycle count toward completion.
      S_COLLECT: if (&(flags_q | lvt_valid)) state_d = S_REDUCE;
      S_REDUCE:  if (last_cmp) state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      idx_q   <= '0;
      min_q   <= '1;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_SAMPLE: begin
          flags_q <= '0;
          idx_q   <= '0;
          min_q   <= '1;
        end
        S_COLLECT: flags_q <= flags_q | lvt_valid;
        S_REDUCE: begin
          min_q <= min_next;
          idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Response capture is pure datapath; the flags qualify it, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_TILES; i++) begin
      if (state_q == S_COLLECT && lvt_valid[i]) lat_q[i] <= lvt[i*VW +: VW];
    end
  end

`ifdef GVT_MONOTONIC_CHECK_EN
  logic err_q;
`endif

  // Publish registers load on the last REDUCE edge so gvt, gvt_valid and done
  // are all aligned with the PUBLISH cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gvt_q       <= '0;
      gvt_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef GVT_MONOTONIC_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      gvt_valid_q <= 1'b0;
      if (state_q == S_REDUCE && last_cmp) begin
        gvt_valid_q <= 1'b1;
        if (min_next == '1) done_q <= 1'b1;
`ifdef GVT_MONOTONIC_CHECK_EN
        // A backwards step is reported and suppressed; the strobe still fires.
        if (min_next < gvt_q) err_q <= 1'b1;
        else                  gvt_q <= min_next;
`else
        gvt_q <= min_next;
`endif
      end
    end
  end

  assign lvt_req   = {N_TILES{state_q == S_SAMPLE}};
  assign gvt       = gvt_q;
  assign gvt_valid = gvt_valid_q;
  assign done      = done_q;
`ifdef GVT_MONOTONIC_CHECK_EN
  assign gvt_err   = err_q;
`endif

endmodule

// File: tb/tb_gvt_arbiter.sv
// Purpose : self-checking bench for gvt_arbiter (N_TILES=8, 64-bit {ts,tb}).
// Latency : expected publish cycle = response cycle + N_TILES + 1.
// Backpressure: bench answers lvt_req one cycle later; expectations go to a scoreboard queue.
module tb_gvt_arbiter;
  localparam int N   = 8;
  localparam int VW  = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic              gvt_en;
  logic [N-1:0]      lvt_req;
  logic [N-1:0]      lvt_valid;
  logic [N*VW-1:0]   lvt;
  logic [VW-1:0]     gvt;
  logic              gvt_valid;
  logic              done;
`ifdef GVT_MONOTONIC_CHECK_EN
  logic              gvt_err;
`endif

  gvt_arbiter #(.N_TILES(N), .TS_WIDTH(32), .TB_WIDTH(32), .LOG_GVT_PERIOD(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .gvt_en    (gvt_en),
    .lvt_req   (lvt_req),
    .lvt_valid (lvt_valid),
    .lvt       (lvt),
    .gvt       (gvt),
    .gvt_valid (gvt_valid),
    .done      (done)
`ifdef GVT_MONOTONIC_CHECK_EN
    ,
    .gvt_err   (gvt_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [VW-1:0] gvt;
    logic          done;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string           name;
    logic [N*VW-1:0] data;
    logic [VW-1:0]   exp_min;
  } vec_t;
  vec_t tbl[5];

  // Reference state: what gvt/done/gvt_err should read after each publish.
  logic [VW-1:0] m_gvt;
  logic          m_done;
  logic          m_err;

  function automatic logic [VW-1:0] mk(input int ts, input int tb);
    logic [31:0] a;
    logic [31:0] b;
    a = ts;
    b = tb;
    return {a, b};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic predict(input logic [VW-1:0] mn, input int pub_cyc);
    exp_t e;
`ifdef GVT_MONOTONIC_CHECK_EN
    if (mn < m_gvt) m_err = 1'b1;
    else            m_gvt = mn;
`else
    m_gvt = mn;
`endif
    if (mn == '1) m_done = 1'b1;
    e.gvt  = m_gvt;
    e.done = m_done;
    e.err  = m_err;
    e.cyc  = pub_cyc;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the request pulse, then returns just after the next
  // rising edge so responses land one cycle after lvt_req.
  task automatic wait_req();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (lvt_req === '1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: lvt_req never all-ones within 300 cycles, expected a round");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] mask, input logic [N*VW-1:0] data);
    lvt_valid = mask;
    lvt       = data;
    @(posedge clk);
    #1;
    lvt_valid = '0;
  endtask

  task automatic wait_pub();
    for (int n = 0; n < 60 && sb.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pub_timeout: %0d publishes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_round(input logic [N*VW-1:0] data, input logic [VW-1:0] mn);
    wait_req();
    predict(mn, cyc + N + 1);
    drive('1, data);
    wait_pub();
  endtask

  // Scoreboard consumer: every gvt_valid must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn === 1'b1 && gvt_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_publish: gvt_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("pub_gvt", gvt, e.gvt);
        check("pub_done", {63'b0, done}, {63'b0, e.done});
        check("pub_cycle", VW'(cyc), VW'(e.cyc));
`ifdef GVT_MONOTONIC_CHECK_EN
        check("pub_err", {63'b0, gvt_err}, {63'b0, e.err});
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*VW-1:0] d;
    int              cnt;

    rstn      = 1'b0;
    gvt_en    = 1'b0;
    lvt_valid = '0;
    lvt       = '0;
    m_gvt     = '0;
    m_done    = 1'b0;
    m_err     = 1'b0;

    // Vector table: hand-derived minima.
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(10*i + 5, i);
    tbl[0] = '{"ascending", d, mk(5, 0)};
    for (int i = 0; i < N; i++) d[i*VW +: VW] = (i == 2 || i == 6) ? mk(7, 3) : mk(9, 0);
    tbl[1] = '{"tie_2_6", d, mk(7, 3)};
    d = '1;
    tbl[2] = '{"all_ones", d, '1};
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(100 - i, 7);
    tbl[3] = '{"min_last_tile", d, mk(93, 7)};
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(31, 0);
    d[5*VW +: VW] = mk(30, 2);
    d[1*VW +: VW] = mk(30, 9);
    tbl[4] = '{"ts_then_tb", d, mk(30, 2)};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gvt", gvt, '0);
    check("rst_gvt_valid", {63'b0, gvt_valid}, '0);
    check("rst_done", {63'b0, done}, '0);
    check("rst_lvt_req", {56'b0, lvt_req}, '0);
`ifdef GVT_MONOTONIC_CHECK_EN
    check("rst_gvt_err", {63'b0, gvt_err}, '0);
`endif
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    gvt_en = 1'b1;

    for (int r = 0; r < 5; r++) begin
      run_round(tbl[r].data, tbl[r].exp_min);
      @(negedge clk);
      check({"hold_gvt_", tbl[r].name}, gvt, m_gvt);
      check({"hold_done_", tbl[r].name}, {63'b0, done}, {63'b0, m_done});
    end

    // Repeat strobe from tile 3 overwrites its earlier value.
    wait_req();
    d = '0;
    d[3*VW +: VW] = mk(1, 0);
    drive(8'b0000_1000, d);
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(60, 0);
    d[3*VW +: VW] = mk(50, 0);
    predict(mk(50, 0), cyc + N + 1);
    drive('1, d);
    wait_pub();

    // Tile 4 answers 100 cycles late: no new round, one publish.
    wait_req();
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(70, 0);
    drive(8'b1110_1111, d);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (lvt_req !== '0) cnt++;
    end
    check("late_no_new_req", VW'(cnt), '0);
    @(posedge clk);
    #1;
    d[4*VW +: VW] = mk(33, 4);
    predict(mk(33, 4), cyc + N + 1);
    drive(8'b0001_0000, d);
    wait_pub();
    repeat (5) @(negedge clk);

    // Reset asserted mid-REDUCE abandons the round.
    wait_req();
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(42, 0);
    drive('1, d);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_gvt", gvt, '0);
    check("midrst_gvt_valid", {63'b0, gvt_valid}, '0);
    check("midrst_done", {63'b0, done}, '0);
    check("midrst_lvt_req", {56'b0, lvt_req}, '0);
    sb.delete();
    m_gvt  = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cnt  = 0;
    repeat (25) begin
      @(negedge clk);
      if (gvt_valid === 1'b1) cnt++;
    end
    check("postrst_no_publish", VW'(cnt), '0);

    // Decreasing minima across rounds: suppressed only with the monotonic guard.
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(20 + i, 0);
    run_round(d, mk(20, 0));
    for (int i = 0; i < N; i++) d[i*VW +: VW] = mk(15 + i, 0);
    run_round(d, mk(15, 0));
    @(negedge clk);
`ifdef GVT_MONOTONIC_CHECK_EN
    check("mono_gvt_held", gvt, mk(20, 0));
    check("mono_err_set", {63'b0, gvt_err}, {63'b0, 1'b1});
`else
    check("nonmono_gvt", gvt, mk(15, 0));
`endif
    check("postrst_done", {63'b0, done}, '0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
